// File: rtl/pillar_pkg.sv
// Shared types and constants for the operand-fetch stage and the ALU it feeds.
package pillar_pkg;

  localparam int XLEN    = 32;
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;
  localparam int IMM_LSB = 20;

  // Stage codes; the ALU decodes the same type on its stage input.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD_A = 3'd1,
    ST_RD_B = 3'd2,
    ST_LOAD = 3'd3,
    ST_EXEC = 3'd4
  } opf_state_t;

  // Sign-extend the 12-bit I-type immediate to the datapath width.
  function automatic logic [XLEN-1:0] sext_imm12(input logic [11:0] imm);
    sext_imm12 = {{(XLEN-12){imm[11]}}, imm};
  endfunction

endpackage

// File: rtl/opf_bypass.sv
// One-entry writeback bypass: registers the writeback snoop every cycle and
// substitutes its data for the register-file read when the addresses match.
// Register 0 never hits, so the hardwired-zero rule is preserved.
module opf_bypass
  import pillar_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            wb_en_i,
  input  logic [4:0]      wb_addr_i,
  input  logic [XLEN-1:0] wb_data_i,
  input  logic [4:0]      sel_addr_i,
  input  logic [XLEN-1:0] rf_data_i,
  output logic [XLEN-1:0] data_o
);

  logic            valid_q;
  logic [4:0]      addr_q;
  logic [XLEN-1:0] data_q;
  logic            hit_s;

  // Capture the writeback seen during the address phase of the read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      addr_q  <= 5'd0;
      data_q  <= {XLEN{1'b0}};
    end else begin
      valid_q <= wb_en_i;
      addr_q  <= wb_addr_i;
      data_q  <= wb_data_i;
    end
  end

  // Select the newer bypass data over the (read-before-write) RF value.
  always_comb begin
    hit_s = valid_q && (addr_q == sel_addr_i) && (sel_addr_i != 5'd0);
    if (hit_s) begin
      data_o = data_q;
    end else begin
      data_o = rf_data_i;
    end
  end

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage upstream of the ALU. Reads rs1 then rs2 through a single
// synchronous register-file port and strobes A, then B and the sign-extended
// immediate, into the ALU. Optional feature: define OPFETCH_BYPASS_EN to add
// a one-entry writeback bypass that hides RF write/read collisions.
module operand_fetch
  import pillar_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            instr_valid_i,
  input  logic [31:0]     instr_i,
  output logic            instr_ready_o,
  input  logic            flush_i,
  output logic [4:0]      rf_addr_o,
  input  logic [XLEN-1:0] rf_data_i,
  input  logic            wb_en_i,
  input  logic [4:0]      wb_addr_i,
  input  logic [XLEN-1:0] wb_data_i,
  output logic [XLEN-1:0] readd_a_o,
  output logic [XLEN-1:0] readd_b_o,
  output logic [XLEN-1:0] readd_pass_o,
  output logic            readin_a_o,
  output logic            readin_b_o,
  output logic            readin_pass_o,
  output logic [2:0]      stage_o
);

  opf_state_t      state_q, state_d;
  logic [4:0]      rs1_q, rs1_d;
  logic [4:0]      rs2_q, rs2_d;
  logic [11:0]     imm_q, imm_d;
  logic [4:0]      sel_addr_s;
  logic [XLEN-1:0] fwd_data_s;
  logic [XLEN-1:0] opnd_s;

`ifdef OPFETCH_BYPASS_EN
  opf_bypass u_bypass (
    .clk        (clk),
    .reset      (reset),
    .wb_en_i    (wb_en_i),
    .wb_addr_i  (wb_addr_i),
    .wb_data_i  (wb_data_i),
    .sel_addr_i (sel_addr_s),
    .rf_data_i  (rf_data_i),
    .data_o     (fwd_data_s)
  );
`else
  // Writeback snoop has no consumer without the bypass.
  logic unused_wb_s;
  assign unused_wb_s = ^{wb_en_i, wb_addr_i, wb_data_i};
  assign fwd_data_s  = rf_data_i;
`endif

  // Register whose data is being returned this cycle, with x0 forced to zero.
  always_comb begin
    if (state_q == ST_LOAD) begin
      sel_addr_s = rs2_q;
    end else begin
      sel_addr_s = rs1_q;
    end
    if (sel_addr_s == 5'd0) begin
      opnd_s = {XLEN{1'b0}};
    end else begin
      opnd_s = fwd_data_s;
    end
  end

  // State and latched instruction fields.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      rs1_q   <= 5'd0;
      rs2_q   <= 5'd0;
      imm_q   <= 12'd0;
    end else begin
      state_q <= state_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      imm_q   <= imm_d;
    end
  end

  // Next state, field capture and ALU-facing outputs; flush overrides all.
  always_comb begin
    state_d       = state_q;
    rs1_d         = rs1_q;
    rs2_d         = rs2_q;
    imm_d         = imm_q;
    instr_ready_o = 1'b0;
    rf_addr_o     = 5'd0;
    readin_a_o    = 1'b0;
    readin_b_o    = 1'b0;
    readin_pass_o = 1'b0;
    readd_a_o     = {XLEN{1'b0}};
    readd_b_o     = {XLEN{1'b0}};
    readd_pass_o  = {XLEN{1'b0}};
    case (state_q)
      ST_IDLE: begin
        instr_ready_o = 1'b1;
        if (instr_valid_i && !flush_i) begin
          rs1_d   = instr_i[RS1_LSB +: 5];
          rs2_d   = instr_i[RS2_LSB +: 5];
          imm_d   = instr_i[IMM_LSB +: 12];
          state_d = ST_RD_A;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD_A: begin
        rf_addr_o = rs1_q;
        if (flush_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RD_B;
        end
      end
      ST_RD_B: begin
        rf_addr_o = rs2_q;
        if (flush_i) begin
          state_d = ST_IDLE;
        end else begin
          readin_a_o = 1'b1;
          readd_a_o  = opnd_s;
          state_d    = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (flush_i) begin
          state_d = ST_IDLE;
        end else begin
          readin_b_o    = 1'b1;
          readd_b_o     = opnd_s;
          readin_pass_o = 1'b1;
          readd_pass_o  = sext_imm12(imm_q);
          state_d       = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign stage_o = state_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch with a behavioural register file.
module tb_operand_fetch;

`ifdef OPFETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid_i;
  logic [31:0] instr_i;
  logic        instr_ready_o;
  logic        flush_i;
  logic [4:0]  rf_addr_o;
  logic [31:0] rf_data_i;
  logic        wb_en_i;
  logic [4:0]  wb_addr_i;
  logic [31:0] wb_data_i;
  logic [31:0] readd_a_o, readd_b_o, readd_pass_o;
  logic        readin_a_o, readin_b_o, readin_pass_o;
  logic [2:0]  stage_o;

  logic [31:0] mem [32];
  int checks = 0;
  int errors = 0;

  operand_fetch dut (
    .clk           (clk),
    .reset         (reset),
    .instr_valid_i (instr_valid_i),
    .instr_i       (instr_i),
    .instr_ready_o (instr_ready_o),
    .flush_i       (flush_i),
    .rf_addr_o     (rf_addr_o),
    .rf_data_i     (rf_data_i),
    .wb_en_i       (wb_en_i),
    .wb_addr_i     (wb_addr_i),
    .wb_data_i     (wb_data_i),
    .readd_a_o     (readd_a_o),
    .readd_b_o     (readd_b_o),
    .readd_pass_o  (readd_pass_o),
    .readin_a_o    (readin_a_o),
    .readin_b_o    (readin_b_o),
    .readin_pass_o (readin_pass_o),
    .stage_o       (stage_o)
  );

  always #5 clk = ~clk;

  // Synchronous read-before-write register file.
  always @(posedge clk) begin
    rf_data_i <= mem[rf_addr_o];
    if (wb_en_i) mem[wb_addr_i] <= wb_data_i;
  end

  function automatic logic [31:0] mk_instr(input logic [4:0] rs1, input logic [4:0] rs2,
                                           input logic [11:0] imm);
    logic [31:0] r;
    r = $urandom;
    r[19:15] = rs1;
    r[24:20] = rs2;
    r[31:20] = imm;
    return r;
  endfunction

  // Operand an instruction should see: value of the register as of the end of
  // its address cycle with the bypass, as of the start without; x0 reads 0.
  function automatic logic [31:0] exp_operand(input logic [4:0] rs);
    logic [31:0] v;
    v = mem[rs];
    if (BYP && wb_en_i && wb_addr_i == rs) v = wb_data_i;
    if (rs == 5'd0) v = 32'd0;
    return v;
  endfunction

  // Drive one instruction through all five cycles, checking every output.
  task automatic run_instr(input logic [31:0] instr, input int flush_cyc, input int wb_cyc,
                           input logic [4:0] wb_a, input logic [31:0] wb_d,
                           input bit rand_wb, input bit keep_valid);
    logic [4:0]  rs1, rs2, exp_addr;
    logic [31:0] exp_a, exp_b, exp_pass;
    logic        ea, eb;
    rs1 = instr[19:15];
    rs2 = instr[24:20];
    exp_pass = {{20{instr[31]}}, instr[31:20]};
    exp_a = 32'd0;
    exp_b = 32'd0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      instr_valid_i = (k == 0) ? 1'b1 : keep_valid;
      instr_i = instr;
      flush_i = (k == flush_cyc);
      if (k == wb_cyc) begin
        wb_en_i = 1'b1; wb_addr_i = wb_a; wb_data_i = wb_d;
      end else if (rand_wb) begin
        wb_en_i = 1'($urandom_range(0, 1)); wb_addr_i = 5'($urandom); wb_data_i = $urandom;
      end else begin
        wb_en_i = 1'b0; wb_addr_i = 5'd0; wb_data_i = 32'd0;
      end
      if (k == 1) exp_a = exp_operand(rs1);
      if (k == 2) exp_b = exp_operand(rs2);
      exp_addr = (k == 1) ? rs1 : (k == 2) ? rs2 : 5'd0;
      ea = (k == 2) && (k != flush_cyc);
      eb = (k == 3) && (k != flush_cyc);
      #1;
      checks++;
      if (stage_o !== 3'(k)) begin
        errors++; $display("FAIL stage k=%0d got %0d expected %0d", k, stage_o, k);
      end
      checks++;
      if (instr_ready_o !== (k == 0)) begin
        errors++; $display("FAIL ready k=%0d got %b expected %b", k, instr_ready_o, (k == 0));
      end
      checks++;
      if (rf_addr_o !== exp_addr) begin
        errors++; $display("FAIL rf_addr k=%0d got %0d expected %0d", k, rf_addr_o, exp_addr);
      end
      checks++;
      if (readin_a_o !== ea || readd_a_o !== (ea ? exp_a : 32'd0)) begin
        errors++; $display("FAIL op_a k=%0d got %b/%h expected %b/%h", k, readin_a_o, readd_a_o,
                           ea, ea ? exp_a : 32'd0);
      end
      checks++;
      if (readin_b_o !== eb || readd_b_o !== (eb ? exp_b : 32'd0)) begin
        errors++; $display("FAIL op_b k=%0d got %b/%h expected %b/%h", k, readin_b_o, readd_b_o,
                           eb, eb ? exp_b : 32'd0);
      end
      checks++;
      if (readin_pass_o !== eb || readd_pass_o !== (eb ? exp_pass : 32'd0)) begin
        errors++; $display("FAIL op_pass k=%0d got %b/%h expected %b/%h", k, readin_pass_o,
                           readd_pass_o, eb, eb ? exp_pass : 32'd0);
      end
      @(posedge clk);
      if (k == flush_cyc) break;
    end
  endtask

  task automatic idle_inputs();
    @(negedge clk);
    instr_valid_i = 1'b0; flush_i = 1'b0; wb_en_i = 1'b0;
    wb_addr_i = 5'd0; wb_data_i = 32'd0;
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (stage_o !== 3'd0 || instr_ready_o !== 1'b1 || rf_addr_o !== 5'd0 ||
        readin_a_o !== 1'b0 || readin_b_o !== 1'b0 || readin_pass_o !== 1'b0 ||
        readd_a_o !== 32'd0 || readd_b_o !== 32'd0 || readd_pass_o !== 32'd0) begin
      errors++;
      $display("FAIL %s got stage=%0d rdy=%b addr=%0d strb=%b%b%b a=%h b=%h p=%h expected idle zeros",
               tag, stage_o, instr_ready_o, rf_addr_o, readin_a_o, readin_b_o, readin_pass_o,
               readd_a_o, readd_b_o, readd_pass_o);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    instr_valid_i = 1'b1; instr_i = 32'hFFFF_FFFF; flush_i = 1'b0;
    wb_en_i = 1'b0; wb_addr_i = 5'd0; wb_data_i = 32'd0;
    for (int i = 0; i < 32; i++) mem[i] = $urandom;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset_state");
    @(negedge clk);
    reset = 1'b0;
    instr_valid_i = 1'b0;
  endtask

  task automatic test_basic();
    mem[3] = 32'h11; mem[5] = 32'h22;
    run_instr(mk_instr(5'd3, 5'd5, 12'hFFF), -1, -1, 5'd0, 32'd0, 1'b0, 1'b0);
    idle_inputs();
  endtask

  task automatic test_zero_reg();
    mem[0] = 32'hDEAD;
    run_instr(mk_instr(5'd0, 5'd0, 12'h123), -1, -1, 5'd0, 32'd0, 1'b0, 1'b0);
    idle_inputs();
  endtask

  task automatic test_flush();
    run_instr(mk_instr(5'd7, 5'd9, 12'h7FF), 3, -1, 5'd0, 32'd0, 1'b0, 1'b0);
    run_instr(mk_instr(5'd1, 5'd2, 12'h800), 0, -1, 5'd0, 32'd0, 1'b0, 1'b0);
    run_instr(mk_instr(5'd4, 5'd6, 12'h001), 1, -1, 5'd0, 32'd0, 1'b0, 1'b0);
    run_instr(mk_instr(5'd4, 5'd6, 12'h001), -1, -1, 5'd0, 32'd0, 1'b0, 1'b0);
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++)
      run_instr(mk_instr(5'($urandom), 5'($urandom), 12'($urandom)), -1, -1, 5'd0, 32'd0,
                1'b0, 1'b1);
    idle_inputs();
  endtask

  task automatic test_bypass();
    mem[3] = 32'h11; mem[5] = 32'h22;
    run_instr(mk_instr(5'd3, 5'd5, 12'h0A5), -1, 2, 5'd5, 32'h99, 1'b0, 1'b0);
    idle_inputs();
    run_instr(mk_instr(5'd5, 5'd3, 12'h0A5), -1, 1, 5'd5, 32'h55, 1'b0, 1'b0);
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    instr_valid_i = 1'b1; instr_i = mk_instr(5'd8, 5'd10, 12'h321);
    mem[8] = 32'hABCD;
    repeat (2) @(posedge clk);
    @(negedge clk);
    instr_valid_i = 1'b0;
    checks++;
    if (stage_o !== 3'd2 || readin_a_o !== 1'b1) begin
      errors++; $display("FAIL pre_reset_rdb got stage=%0d strobe=%b expected 2/1", stage_o, readin_a_o);
    end
    reset = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_reset_outputs("after_reset");
    run_instr(mk_instr(5'd8, 5'd10, 12'h321), -1, -1, 5'd0, 32'd0, 1'b0, 1'b0);
    idle_inputs();
  endtask

  task automatic test_random();
    int fc;
    for (int i = 0; i < 60; i++) begin
      fc = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 4)) : -1;
      run_instr(mk_instr(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 12'($urandom)),
                fc, -1, 5'd0, 32'd0, 1'b1, 1'($urandom_range(0, 1)));
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_reg();
    test_flush();
    test_back_to_back();
    test_bypass();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
